// File: rtl/sw_input_stage.sv
// sw_input_stage -- board input front end for the select_action stage.
//
// Synchronises the slide switches and two push buttons, debounces the
// buttons, latches the switch word on a capture press and steps the operating
// mode on a mode press. A one-cycle update_stb follows every change.
//
// Optional build macro: SW_INPUT_AUTO_REPEAT_EN
//   defined   -> holding the mode button issues an extra mode press every
//                REPEAT_CYCLES cycles while the press stays accepted
//   undefined -> one mode press per hold, REPEAT_CYCLES unused
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   raw_sw       unsynchronised slide switches
//   btn_capture  raw capture button, active-high
//   btn_mode     raw mode button, active-high
//   SW           registered switch word
//   SELECTOR     registered operating mode
//   update_stb   one-cycle pulse when SW or SELECTOR was just updated
//   busy         high while either debouncer is qualifying an edge

package types_pkg;
    localparam int BITS = 16;
    typedef logic [BITS-1:0] word_t;
    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        AND_OP = 2'd2,
        OR_OP  = 2'd3
    } opr_mode_t;
endpackage

// sw_debounce -- four-state level debouncer with one-cycle press pulse.
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   sync_in     synchronised button level
//   sync_ok     synchroniser has filled since reset
//   press       registered one-cycle pulse on an accepted press
//   checking    state is CHK_HIGH or CHK_LOW
//   held        state is HELD_HIGH
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE_LOW  | button accepted as released
// CHK_HIGH  | button seen high, counting stable-high cycles
// HELD_HIGH | press accepted, waiting for release
// CHK_LOW   | button seen low, counting stable-low cycles
module sw_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    input  logic sync_ok,
    output logic press,
    output logic checking,
    output logic held
);
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        HELD_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } state_t;

    localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

    state_t      state;
    logic [15:0] count;
    logic [15:0] count_inc;
    // A button already held when reset releases must be seen low once
    // before it can produce a press.
    logic        armed;

    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
    assign checking  = (state == CHK_HIGH) || (state == CHK_LOW);
    assign held      = (state == HELD_HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LOW;
            count <= '0;
            press <= 1'b0;
            armed <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sync_ok) begin
                        if (!sync_in) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= CHK_HIGH;
                            count <= '0;
                        end
                    end
                end
                CHK_HIGH: begin
                    if (!sync_in) begin
                        state <= IDLE_LOW;
                    end else begin
                        count <= count_inc;
                        if (count_inc == LAST) begin
                            state <= HELD_HIGH;
                            press <= 1'b1;
                        end
                    end
                end
                HELD_HIGH: begin
                    if (!sync_in) begin
                        state <= CHK_LOW;
                        count <= '0;
                    end
                end
                CHK_LOW: begin
                    if (sync_in) begin
                        state <= HELD_HIGH;
                    end else begin
                        count <= count_inc;
                        if (count_inc == LAST) begin
                            state <= IDLE_LOW;
                        end
                    end
                end
                default: state <= IDLE_LOW;
            endcase
        end
    end
endmodule

module sw_input_stage #(
    parameter int          BITS            = types_pkg::BITS,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BITS-1:0]      raw_sw,
    input  logic                 btn_capture,
    input  logic                 btn_mode,
    output types_pkg::word_t     SW,
    output types_pkg::opr_mode_t SELECTOR,
    output logic                 update_stb,
    output logic                 busy
);
    logic [BITS-1:0] sw_s1, sw_s2;
    logic            cap_s1, cap_s2;
    logic            mode_s1, mode_s2;
    logic [1:0]      ok_sh;

    logic cap_press, cap_chk, cap_held;
    logic mode_press, mode_chk, mode_held;
    logic rpt_press;
    logic mode_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            cap_s1  <= 1'b0;
            cap_s2  <= 1'b0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            ok_sh   <= 2'b00;
        end else begin
            sw_s1   <= raw_sw;
            sw_s2   <= sw_s1;
            cap_s1  <= btn_capture;
            cap_s2  <= cap_s1;
            mode_s1 <= btn_mode;
            mode_s2 <= mode_s1;
            // Tracks the synchroniser fill so reset-forced zeros are not
            // mistaken for a real release.
            ok_sh   <= {ok_sh[0], 1'b1};
        end
    end

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cap_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_in  (cap_s2),
        .sync_ok  (ok_sh[1]),
        .press    (cap_press),
        .checking (cap_chk),
        .held     (cap_held)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_in  (mode_s2),
        .sync_ok  (ok_sh[1]),
        .press    (mode_press),
        .checking (mode_chk),
        .held     (mode_held)
    );

    assign busy = cap_chk | mode_chk;

`ifdef SW_INPUT_AUTO_REPEAT_EN
    logic [23:0] rpt_cnt;
    logic        unused_rpt;

    assign unused_rpt = cap_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_press <= 1'b0;
        end else if (!mode_held) begin
            rpt_cnt   <= '0;
            rpt_press <= 1'b0;
        end else if (rpt_cnt == REPEAT_CYCLES - 24'd1) begin
            rpt_cnt   <= '0;
            rpt_press <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 24'd1;
            rpt_press <= 1'b0;
        end
    end
`else
    logic unused_rpt;

    assign unused_rpt = ^{REPEAT_CYCLES, mode_held, cap_held};
    assign rpt_press  = 1'b0;
`endif

    assign mode_step = mode_press | rpt_press;

    function automatic types_pkg::opr_mode_t next_mode(input types_pkg::opr_mode_t m);
        case (m)
            types_pkg::ADD:    next_mode = types_pkg::SUB;
            types_pkg::SUB:    next_mode = types_pkg::AND_OP;
            types_pkg::AND_OP: next_mode = types_pkg::OR_OP;
            default:           next_mode = types_pkg::ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SW         <= '0;
            SELECTOR   <= types_pkg::ADD;
            update_stb <= 1'b0;
        end else begin
            update_stb <= cap_press | mode_step;
            if (cap_press) begin
                SW <= sw_s2;
            end
            if (mode_step) begin
                SELECTOR <= next_mode(SELECTOR);
            end
        end
    end
endmodule

// File: tb/tb_sw_input_stage.sv
// Scoreboard bench for sw_input_stage with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
// Stimulus pushes the expected {SW, SELECTOR, strobe cycle} for every press;
// a monitor pops one entry per update_stb and compares.
module tb_sw_input_stage;
    import types_pkg::*;

    localparam int LAT = 2 + 4 + 1;
    localparam int RPT = 20;

    logic        clk;
    logic        rst_n;
    logic [15:0] raw_sw;
    logic        btn_capture;
    logic        btn_mode;
    word_t       SW;
    opr_mode_t   SELECTOR;
    logic        update_stb;
    logic        busy;

    sw_input_stage #(
        .BITS            (16),
        .DEBOUNCE_CYCLES (16'd4),
        .REPEAT_CYCLES   (24'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_sw      (raw_sw),
        .btn_capture (btn_capture),
        .btn_mode    (btn_mode),
        .SW          (SW),
        .SELECTOR    (SELECTOR),
        .update_stb  (update_stb),
        .busy        (busy)
    );

    typedef struct {
        logic [15:0] sw;
        opr_mode_t   sel;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] model_sw;
    opr_mode_t   model_sel;
    bit          busy_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (busy) busy_seen = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic opr_mode_t nxt(input opr_mode_t m);
        opr_mode_t order [4];
        order[0] = ADD; order[1] = SUB; order[2] = AND_OP; order[3] = OR_OP;
        nxt = ADD;
        for (int i = 0; i < 4; i++)
            if (order[i] == m) nxt = order[(i + 1) % 4];
    endfunction

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && update_stb) begin
            if (sb.size() == 0) begin
                chk("unexpected_stb", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("stb_cycle", 32'(cyc), 32'(e.cyc));
                chk("stb_sw", 32'(SW), 32'(e.sw));
                chk("stb_sel", 32'(SELECTOR), 32'(e.sel));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_press(input logic cap, input logic mode, input int hold,
                            input int gap, input int n_rep);
        int   c0;
        exp_t e;
        tick(1);
        c0 = cyc;
        btn_capture = cap;
        btn_mode    = mode;
        if (cap)  model_sw  = raw_sw;
        if (mode) model_sel = nxt(model_sel);
        e.sw = model_sw; e.sel = model_sel; e.cyc = c0 + LAT;
        sb.push_back(e);
        for (int k = 1; k <= n_rep; k++) begin
            model_sel = nxt(model_sel);
            e.sw = model_sw; e.sel = model_sel; e.cyc = c0 + LAT + RPT * k;
            sb.push_back(e);
        end
        tick(hold);
        btn_capture = 1'b0;
        btn_mode    = 1'b0;
        tick(gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        raw_sw      = 16'h0000;
        btn_capture = 1'b1;
        btn_mode    = 1'b1;
        model_sw    = 16'h0000;
        model_sel   = ADD;
        busy_seen   = 1'b0;

        // Reset with buttons held; no press after release until re-pressed.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sw", 32'(SW), 32'h0);
        chk("rst_sel", 32'(SELECTOR), 32'(ADD));
        chk("rst_stb", 32'(update_stb), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(20);
        btn_capture = 1'b0;
        btn_mode    = 1'b0;
        tick(12);
        chk("held_after_rst_sel", 32'(SELECTOR), 32'(ADD));

        // Capture, held 10 cycles: one strobe, SW at +7.
        raw_sw = 16'hA5C3;
        tick(3);
        do_press(1'b1, 1'b0, 10, 12, 0);
        chk("capture_sw", 32'(SW), 32'hA5C3);

        // Bounce shorter than the debounce window.
        tick(1);
        busy_seen = 1'b0;
        btn_mode = 1'b1; tick(1);
        btn_mode = 1'b0; tick(1);
        btn_mode = 1'b1; tick(1);
        btn_mode = 1'b0; tick(12);
        chk("bounce_busy_seen", 32'(busy_seen), 32'h1);
        chk("bounce_sel", 32'(SELECTOR), 32'(ADD));

        // Full mode wrap.
        for (int i = 0; i < 4; i++) begin
            do_press(1'b0, 1'b1, 8, 10, 0);
        end
        chk("wrap_sel", 32'(SELECTOR), 32'(ADD));

        // Simultaneous capture and mode press.
        raw_sw = 16'h0001;
        tick(3);
        do_press(1'b1, 1'b1, 8, 10, 0);
        chk("simul_sw", 32'(SW), 32'h0001);
        chk("simul_sel", 32'(SELECTOR), 32'(SUB));

        // Long mode hold.
`ifdef SW_INPUT_AUTO_REPEAT_EN
        do_press(1'b0, 1'b1, 70, 12, 3);
`else
        do_press(1'b0, 1'b1, 70, 12, 0);
`endif
        chk("hold_sel", 32'(SELECTOR), 32'(model_sel));

        // Reset in the middle of a capture debounce, button still held after.
        raw_sw = 16'h1234;
        tick(3);
        btn_capture = 1'b1;
        tick(4);
        rst_n = 1'b0;
        model_sw  = 16'h0000;
        model_sel = ADD;
        tick(2);
        chk("midrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(20);
        btn_capture = 1'b0;
        tick(12);
        chk("midrst_sw", 32'(SW), 32'h0);
        chk("midrst_sel", 32'(SELECTOR), 32'(ADD));

        // Capture still works after the aborted debounce.
        do_press(1'b1, 1'b0, 8, 10, 0);
        tick(5);
        chk("final_queue_empty", 32'(sb.size()), 32'h0);
        chk("final_sw", 32'(SW), 32'(model_sw));
        chk("final_sel", 32'(SELECTOR), 32'(model_sel));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_input_stage.md
Name: sw_input_stage

Overview:
- Front-end stage that conditions raw board inputs (slide switches and two push buttons) and drives the SW word and SELECTOR mode into the downstream select_action stage.
- Synchronises and debounces the buttons.
- Captures the switch word on a debounced capture press and advances the operating mode on a debounced mode press.
- Emits a one-cycle update strobe whenever either downstream input changes.

Parameters:
- BITS, types_pkg::BITS (16): switch/word width; must equal width of word_t.
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles required before a button level is accepted; legal range 2..65535.
- REPEAT_CYCLES, 24'd5000000: hold time per auto-repeat step; used only with the optional feature.

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst_n  in  1  asynchronous assert, active-low reset; deasserted synchronously to clk by the board reset logic.
- raw_sw  in  BITS  unsynchronised slide switches.
- btn_capture  in  1  raw capture push button, active-high.
- btn_mode  in  1  raw mode push button, active-high.
- SW  out  word_t  registered switch word to select_action.
- SELECTOR  out  opr_mode_t  registered operating mode to select_action.
- update_stb  out  1  one-cycle pulse, cycle after SW or SELECTOR changes.
- busy  out  1  high while either button debouncer is counting.

Behaviour:
- Reset (rst_n=0, asynchronous): SW='0, SELECTOR=ADD, update_stb=0, busy=0, both debouncers in IDLE_LOW with count 0, synchronisers cleared to 0.
- Synchronisation: raw_sw, btn_capture and btn_mode each pass through a 2-flop synchroniser; all logic below sees synchronised values only.
- Debouncer, one per button, states IDLE_LOW -> CHK_HIGH -> HELD_HIGH -> CHK_LOW -> IDLE_LOW:
  - IDLE_LOW: sync=1 -> CHK_HIGH, count=0.
  - CHK_HIGH: sync=0 -> IDLE_LOW. Otherwise count++; when count reaches DEBOUNCE_CYCLES-1 -> HELD_HIGH and assert the internal press pulse for exactly one cycle.
  - HELD_HIGH: sync=0 -> CHK_LOW, count=0.
  - CHK_LOW: sync=1 -> HELD_HIGH. Otherwise count++; at DEBOUNCE_CYCLES-1 -> IDLE_LOW. No pulse on release.
  - Counter saturates and never wraps.
  - busy = OR of (state is CHK_HIGH or CHK_LOW) across both debouncers.
- Capture: on capture press, SW <= synchronised raw_sw in the same cycle as the pulse. The new SW is visible one clk later.
  - Total latency from a stable raw press: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Mode: on mode press, SELECTOR advances to the next opr_mode_t enumerator in declaration order. The last enumerator wraps to the first (ADD).
- update_stb: asserted the cycle after a capture or mode press, for one cycle only.
  - Asserted even if the captured value equals the previous SW.
- Simultaneous capture and mode presses in the same cycle: both apply; one update_stb.
- A button held indefinitely yields exactly one press.
- A glitch shorter than DEBOUNCE_CYCLES yields no press and no output change.
- Reset mid-debounce: count and state cleared immediately; no pulse is emitted on release of reset even if the button is still held. The debouncer restarts from IDLE_LOW.

Optional Feature:
- Macro SW_INPUT_AUTO_REPEAT_EN.
- Defined: while the mode debouncer is in HELD_HIGH, a 24-bit repeat counter increments.
  - Each time it reaches REPEAT_CYCLES-1 it clears and issues an additional mode press (SELECTOR advances, update_stb pulses).
  - The counter clears on leaving HELD_HIGH and on reset. Capture never auto-repeats.
- Undefined: no repeat counter is synthesised; one press per hold as above; REPEAT_CYCLES is ignored.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
- Reset: rst_n low for 3 cycles with buttons high -> SW=0, SELECTOR=ADD, update_stb=0, busy=0. After release, with buttons still held, there is no press until a release/press cycle completes.
- Capture: raw_sw=16'hA5C3, btn_capture high for 10 cycles -> SW=16'hA5C3 exactly 2+4+1 cycles after assertion; update_stb high for one cycle; a single capture.
- Bounce: btn_mode toggled 1,0,1,0 on successive cycles, then held low -> SELECTOR stays ADD, update_stb never asserts, busy pulses.
- Mode wrap: N clean mode presses, where N = number of opr_mode_t enumerators -> SELECTOR visits every enumerator in order and returns to ADD; N update_stb pulses.
- Simultaneous: both buttons pressed on the same cycle with raw_sw=16'h0001 -> SW=1, SELECTOR=next after ADD, exactly one update_stb.
- Auto-repeat (macro defined): btn_mode held for 70 cycles -> 1 initial press plus 3 repeats. The same stimulus with the macro undefined -> 1 press.
